// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
package hazard_ctrl_pkg;

  // Controller FSM encodings; 2'd3 is unused and treated as illegal.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // Register $0 never carries a real dependency.
  localparam logic [4:0] ZERO_REG = 5'd0;

  // Consecutive memory wait cycles before the sticky timeout flag sets.
  localparam int DEF_MEM_TIMEOUT = 16;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard inputs and pipeline-register controls.
interface hazard_ctrl_if;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic       pipe_hold;

  // Controller side: observes the pipeline, drives the register controls.
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           ex_branch_taken, mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold
  );

  // Pipeline side: presents hazard information, obeys the controls.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  // Count enabled cycles, holding at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 32'd0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch / memory-wait hazard controller for the 5-stage pipeline.
// Controls are decoded combinationally from the current hazard terms; the FSM,
// wait-length tracking and counters are for status reporting only.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz,
  output logic [1:0]    state,
  output logic [31:0]   stall_count,
  output logic [31:0]   flush_count,
  output logic [31:0]   wait_count,
  output logic          mem_timeout
);

  localparam logic [4:0] TIMEOUT_LEN = 5'(MEM_TIMEOUT - 1);

  logic   freeze;
  logic   lu;
  logic   br;
  state_t state_r;
  state_t state_next;
  logic [4:0] wlen;

  assign freeze = hz.mem_req & ~hz.mem_ready;
  assign lu     = hz.ex_memread & (hz.ex_rt != ZERO_REG) &
                  ((hz.ex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));
  assign br     = hz.ex_branch_taken;
  assign state  = state_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic: tracks entry to, duration of and exit from memory waits.
  always_comb begin
    state_next = RUN;
    case (state_r)
      RUN:     state_next = freeze ? WAIT : RUN;
      WAIT:    state_next = freeze ? WAIT : RECOVER;
      RECOVER: state_next = freeze ? WAIT : RUN;
      default: state_next = RUN;
    endcase
  end

  // Control decode: freeze beats branch, branch beats load-use.
  always_comb begin
    hz.pc_write   = 1'b1;
    hz.ifid_write = 1'b1;
    hz.ifid_flush = 1'b0;
    hz.idex_flush = 1'b0;
    hz.pipe_hold  = 1'b0;
    if (freeze) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.pipe_hold  = 1'b1;
    end else if (br) begin
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (lu) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.idex_flush = 1'b1;
    end else begin
      hz.pc_write   = 1'b1;
    end
  end

  // Length of the current wait; saturates so a long wait cannot wrap back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wlen <= 5'd0;
    end else if (!freeze) begin
      wlen <= 5'd0;
    end else if (wlen != 5'h1F) begin
      wlen <= wlen + 5'd1;
    end else begin
      wlen <= wlen;
    end
  end

  // Sticky timeout: set on the edge closing the MEM_TIMEOUT-th freeze cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_timeout <= 1'b0;
    end else if (freeze && (wlen == TIMEOUT_LEN)) begin
      mem_timeout <= 1'b1;
    end else begin
      mem_timeout <= mem_timeout;
    end
  end

  sat_counter32 u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (lu & ~br & ~freeze),
    .count (stall_count)
  );

  sat_counter32 u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (br & ~freeze),
    .count (flush_count)
  );

  sat_counter32 u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (freeze),
    .count (wait_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus
// against a cycle-history reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  state;
  logic [31:0] stall_count, flush_count, wait_count;
  logic        mem_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  longint unsigned m_stall, m_flush, m_wait;
  bit m_timeout;
  int m_run;
  bit m_h1, m_h2;

  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .hz          (hif),
    .state       (state),
    .stall_count (stall_count),
    .flush_count (flush_count),
    .wait_count  (wait_count),
    .mem_timeout (mem_timeout)
  );

  wire [4:0] ctrl = {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_flush, hif.pipe_hold};

  // {freeze, load_use, branch} from the current inputs
  function automatic logic [2:0] terms();
    logic fr, l, b;
    fr = hif.mem_req && !hif.mem_ready;
    l  = hif.ex_memread && (hif.ex_rt != 5'd0) &&
         ((hif.ex_rt == hif.id_rs) || (hif.id_uses_rt && (hif.ex_rt == hif.id_rt)));
    b  = hif.ex_branch_taken;
    return {fr, l, b};
  endfunction

  // Expected {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}
  function automatic logic [4:0] exp_ctrl();
    logic [2:0] t;
    t = terms();
    if (t[2]) return 5'b00001;
    if (t[0]) return 5'b11110;
    if (t[1]) return 5'b00010;
    return 5'b11000;
  endfunction

  // State follows freeze history: last cycle froze -> WAIT, the one before -> RECOVER
  function automatic logic [1:0] exp_state();
    if (m_h1) return 2'd1;
    if (m_h2) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_clear();
    m_stall = 0; m_flush = 0; m_wait = 0;
    m_timeout = 1'b0; m_run = 0; m_h1 = 1'b0; m_h2 = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] t;
    t = terms();
    if (!t[2] && t[1] && !t[0] && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (!t[2] && t[0] && m_flush < 64'hFFFF_FFFF) m_flush++;
    if (t[2] && m_wait < 64'hFFFF_FFFF) m_wait++;
    if (t[2]) begin
      m_run++;
      if (m_run >= TMO) m_timeout = 1'b1;
    end else begin
      m_run = 0;
    end
    m_h2 = m_h1;
    m_h1 = t[2];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic memread, input logic [4:0] ert, input logic b,
                        input logic mreq, input logic mrdy);
    hif.id_rs = rs; hif.id_rt = rt; hif.id_uses_rt = uses;
    hif.ex_memread = memread; hif.ex_rt = ert; hif.ex_branch_taken = b;
    hif.mem_req = mreq; hif.mem_ready = mrdy;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    model_clear();
    n_checks++;
    if (ctrl !== 5'b11000) begin
      n_errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 5'b11000);
    end
    n_checks++;
    if ({state, stall_count, flush_count, wait_count, mem_timeout} !== 99'd0) begin
      n_errors++;
      $display("FAIL reset_status: state=%0d stall=%0d flush=%0d wait=%0d tmo=%b want all 0",
               state, stall_count, flush_count, wait_count, mem_timeout);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctrl !== 5'b00010) begin
      n_errors++; $display("FAIL lu_rs_ctrl: got %b want %b", ctrl, 5'b00010);
    end
    tick();
    n_checks++;
    if (stall_count !== 32'd1 || m_stall != 1) begin
      n_errors++; $display("FAIL lu_rs_count: got %0d want 1", stall_count);
    end
    set_in(5'd8, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctrl !== 5'b11000) begin
      n_errors++; $display("FAIL lu_release_ctrl: got %b want %b", ctrl, 5'b11000);
    end
    tick();
  endtask

  task automatic test_load_zero();
    do_reset();
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctrl !== 5'b11000) begin
      n_errors++; $display("FAIL lu_zero_ctrl: got %b want %b", ctrl, 5'b11000);
    end
    tick();
    n_checks++;
    if (stall_count !== 32'd0) begin
      n_errors++; $display("FAIL lu_zero_count: got %0d want 0", stall_count);
    end
  endtask

  task automatic test_branch_lu();
    do_reset();
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ctrl !== 5'b11110) begin
      n_errors++; $display("FAIL br_lu_ctrl: got %b want %b", ctrl, 5'b11110);
    end
    tick();
    n_checks++;
    if (flush_count !== 32'd1 || stall_count !== 32'd0) begin
      n_errors++; $display("FAIL br_lu_counts: flush=%0d stall=%0d want 1 and 0", flush_count, stall_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(5'd5, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ctrl !== 5'b11000) begin
      n_errors++; $display("FAIL b2b_bubble_ctrl: got %b want %b", ctrl, 5'b11000);
    end
    tick();
    set_in(5'd1, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(5'd1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (stall_count !== 32'd2) begin
      n_errors++; $display("FAIL b2b_count: got %0d want 2", stall_count);
    end
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_seq [0:4];
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd1; exp_seq[2] = 2'd1; exp_seq[3] = 2'd2; exp_seq[4] = 2'd0;
    do_reset();
    n_checks++;
    if (state !== 2'd0) begin
      n_errors++; $display("FAIL wait_state_start: got %0d want 0", state);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      else if (i == 3) set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      else set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (i < 3 && ctrl !== 5'b00001) begin
        n_errors++; $display("FAIL wait_hold_ctrl[%0d]: got %b want %b", i, ctrl, 5'b00001);
      end else if (i == 3 && ctrl !== 5'b11110) begin
        n_errors++; $display("FAIL wait_release_flush: got %b want %b", ctrl, 5'b11110);
      end
      tick();
      n_checks++;
      if (state !== exp_seq[i]) begin
        n_errors++; $display("FAIL wait_state[%0d]: got %0d want %0d", i, state, exp_seq[i]);
      end
    end
    n_checks++;
    if (wait_count !== 32'd3 || flush_count !== 32'd1) begin
      n_errors++; $display("FAIL wait_counts: wait=%0d flush=%0d want 3 and 1", wait_count, flush_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= TMO; i++) begin
      tick();
      n_checks++;
      if (mem_timeout !== (i == TMO)) begin
        n_errors++; $display("FAIL timeout_edge[%0d]: got %b want %b", i, mem_timeout, (i == TMO));
      end
    end
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (mem_timeout !== 1'b1 || wait_count !== 32'(TMO)) begin
      n_errors++; $display("FAIL timeout_sticky: tmo=%b wait=%0d want 1 and %0d", mem_timeout, wait_count, TMO);
    end
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if ({state, stall_count, flush_count, wait_count, mem_timeout} !== 99'd0) begin
      n_errors++;
      $display("FAIL timeout_async_reset: state=%0d stall=%0d flush=%0d wait=%0d tmo=%b want all 0",
               state, stall_count, flush_count, wait_count, mem_timeout);
    end
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count;
    m_stall = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (stall_count !== 32'(m_stall)) begin
        n_errors++; $display("FAIL sat_step[%0d]: got %h want %h", i, stall_count, 32'(m_stall));
      end
    end
    n_checks++;
    if (stall_count !== 32'hFFFF_FFFF) begin
      n_errors++; $display("FAIL sat_final: got %h want ffffffff", stall_count);
    end
  endtask

  task automatic test_random();
    logic [4:0] ec;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)),
             (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0));
      ec = exp_ctrl();
      n_checks++;
      if (ctrl !== ec) begin
        n_errors++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i, ctrl, ec);
      end
      tick();
      n_checks++;
      if (stall_count !== 32'(m_stall) || flush_count !== 32'(m_flush) ||
          wait_count !== 32'(m_wait) || mem_timeout !== m_timeout || state !== exp_state()) begin
        n_errors++;
        $display("FAIL rand_status[%0d]: got st=%0d s=%0d f=%0d w=%0d t=%b want st=%0d s=%0d f=%0d w=%0d t=%b",
                 i, state, stall_count, flush_count, wait_count, mem_timeout,
                 exp_state(), m_stall, m_flush, m_wait, m_timeout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_zero();
    test_branch_lu();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
